wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Arbitrates write-back requests from NUM_REQ producers onto the NUM_PORTS write ports of the 32-bit register file (ports 1..4 = wr_* slots 0..3).
- Producers: ALU, load unit, OTF/FTO dual-result paths, and others.
- Round-robin with starvation override; same-cycle same-address conflicts are resolved in scan order, so write order is preserved.
- Sits between the MEM/WB pipeline register and the register-file write ports. Its backpressure feeds the hazard controller's stall.

Parameters:
- NUM_REQ, 6, number of write-back requesters.
- NUM_PORTS, 4, register-file write ports driven.
- AW, 5, register address width.
- DW, 32, write data width.
- STARVE_LIMIT, 3, wait cycles before a requester is promoted to top priority.
- CW, 2, width of each per-requester wait counter (must hold STARVE_LIMIT).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  requester i holds a write.
- req_addr  in  NUM_REQ*AW  requester i destination at [i*AW +: AW].
- req_data  in  NUM_REQ*DW  requester i data at [i*DW +: DW].
- req_ready  out  NUM_REQ  requester i accepted this cycle (combinational).
- wr_en  out  NUM_PORTS  register-file write enable per port (registered).
- wr_addr  out  NUM_PORTS*AW  per-port write address (registered).
- wr_data  out  NUM_PORTS*DW  per-port write data (registered).
- wb_stall  out  1  some valid requester was not accepted this cycle (combinational).

Behaviour:
- Handshake: transfer on req_valid[i] && req_ready[i]. A requester holds valid/addr/data stable until accepted. req_ready[i] is high only when valid and granted.
- Scan order each cycle:
  - First, starved requesters (wait_cnt >= STARVE_LIMIT), in ascending index.
  - Then all remaining requesters in rotation from rr_ptr, i.e. rr_ptr, rr_ptr+1, ... mod NUM_REQ.
- Grant rules, applied in scan order:
  - Grant a valid requester if fewer than NUM_PORTS grants are made so far.
  - Its addr must not equal the addr of any requester already granted this cycle.
  - A conflicting requester is denied and retries next cycle.
- Port packing: the k-th grant in scan order goes to port k. Unused ports next cycle have wr_en=0 and addr/data=0.
- Latency: accepted at edge N means wr_en/addr/data are valid in cycle N+1 (exactly one cycle).
- rr_ptr: on any grant, rr_ptr <= (index of last granted requester in scan order + 1) mod NUM_REQ. With no grant, rr_ptr is unchanged.
- wait_cnt[i]:
  - Cleared when granted or when req_valid[i]=0.
  - Incremented (saturating at STARVE_LIMIT) when valid and not granted.
- wb_stall = OR over i of (req_valid[i] && !req_ready[i]).
- Reset (rst high at an edge, including mid-stream):
  - wr_en=0, wr_addr=0, wr_data=0, rr_ptr=0, all wait_cnt=0.
  - req_ready is forced 0 and wb_stall is forced 0 while rst is high.
  - In-flight registered writes are discarded. Requesters keep valid and retry after reset.
- Boundaries:
  - All NUM_REQ valid with distinct addresses: exactly NUM_PORTS granted. The rest stall, and their wait_cnt increments.
  - Starved set larger than NUM_PORTS: lowest indices win. Others remain starved.
  - No valid requests: wr_en=0 next cycle and state is unchanged apart from wait_cnt clears.
  - Address 0 is treated like any other address (no special-casing).

Optional Feature:
- Macro: WB_ARB_PERF_EN.
- Defined: adds outputs perf_grants (32b) and perf_stall_cycles (32b).
  - perf_grants increments by the number of grants each cycle.
  - perf_stall_cycles increments by 1 on each cycle with wb_stall=1.
  - Both wrap modulo 2^32 and are cleared by rst.
- Undefined: neither port nor counter exists. All other behaviour is identical.

Test Plan:
- Reset then req_valid=6'b000011, addrs 5 and 9, data 0xA/0xB → same cycle req_ready=6'b000011, wb_stall=0. Next cycle wr_en=4'b0011, port0=(5,0xA), port1=(9,0xB), rr_ptr=2.
- All 6 valid, distinct addrs 1..6, rr_ptr=0 → req_ready=6'b001111, wb_stall=1. Next cycle ports carry addrs 1,2,3,4, and rr_ptr=4. Following cycle, with reqs 4 and 5 still valid → both granted onto ports 0,1.
- Requesters 0 and 3 both valid, addr 7, rr_ptr=2 → only req 3 is granted; req 0 is granted the next cycle. Writes to addr 7 appear in order 3 then 0.
- Requester 5 held valid while 0..3 are continuously valid, rr_ptr pinned → req 5 is granted no later than the cycle after its wait_cnt reaches 3, on port 0.
- Assert rst for 1 cycle while 4 writes are registered → next cycle wr_en=0, rr_ptr=0. After rst drops, still-valid requests are re-granted from index 0.
- WB_ARB_PERF_EN: 10 cycles of 6 valid distinct requests with reqs re-asserted after each accept → perf_grants=40, perf_stall_cycles=10.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_port_arbiter_if
//  Purpose  : Write-back request/grant bus and register-file write-port bus
//             shared between the producers, the arbiter and the register file.
//  Revision : 1.0  initial release
// ============================================================================
interface wb_port_arbiter_if #(
    parameter int NUM_REQ   = 6,
    parameter int NUM_PORTS = 4,
    parameter int AW        = 5,
    parameter int DW        = 32
) ();
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*AW-1:0]     req_addr;
    logic [NUM_REQ*DW-1:0]     req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_PORTS-1:0]      wr_en;
    logic [NUM_PORTS*AW-1:0]   wr_addr;
    logic [NUM_PORTS*DW-1:0]   wr_data;
    logic                      wb_stall;

    // Producer / register-file side
    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, wr_en, wr_addr, wr_data, wb_stall
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, wr_en, wr_addr, wr_data, wb_stall
    );
endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_port_arbiter
//  Purpose  : Round-robin write-back arbiter with starvation override that
//             packs up to NUM_PORTS same-cycle grants onto the register-file
//             write ports, denying same-address conflicts in scan order.
//  Options  : define WB_ARB_PERF_EN to add perf_grants / perf_stall_cycles.
//  Revision : 1.0  initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int NUM_REQ      = 6,
    parameter int NUM_PORTS    = 4,
    parameter int AW           = 5,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 3,
    parameter int CW           = 2
) (
    input  logic               clk,
    input  logic               rst,
    wb_port_arbiter_if.slave   bus
`ifdef WB_ARB_PERF_EN
    ,
    output logic [31:0]        perf_grants,
    output logic [31:0]        perf_stall_cycles
`endif
);

    localparam int            PW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    logic [AW-1:0]        addr_a     [NUM_REQ];
    logic [DW-1:0]        data_a     [NUM_REQ];
    logic [CW-1:0]        wait_cnt   [NUM_REQ];
    logic [NUM_REQ-1:0]   starved;
    logic [NUM_REQ-1:0]   grant;

    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        nxt_ptr;

    logic [NUM_PORTS-1:0] nxt_en;
    logic [AW-1:0]        nxt_addr   [NUM_PORTS];
    logic [DW-1:0]        nxt_data   [NUM_PORTS];
    logic [NUM_PORTS-1:0] wr_en_q;
    logic [AW-1:0]        wr_addr_q  [NUM_PORTS];
    logic [DW-1:0]        wr_data_q  [NUM_PORTS];

    // Unpack the flat request buses and flag starved requesters
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign addr_a[gi]  = bus.req_addr[gi*AW +: AW];
            assign data_a[gi]  = bus.req_data[gi*DW +: DW];
            assign starved[gi] = (wait_cnt[gi] >= STARVE_MAX);
        end
    endgenerate

    // Scan: starved requesters in ascending index first, then the rest in
    // rotation from rr_ptr. Each grant takes the next free port unless its
    // address matches one already granted this cycle.
    always_comb begin : p_scan
        int   n_grant;
        int   last_idx;
        int   idx;
        logic conflict;
        n_grant  = 0;
        last_idx = int'(rr_ptr);
        idx      = 0;
        conflict = 1'b0;
        grant    = '0;
        nxt_en   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            nxt_addr[p] = '0;
            nxt_data[p] = '0;
        end
        for (int s = 0; s < 2*NUM_REQ; s++) begin
            idx = (s < NUM_REQ) ? s : ((int'(rr_ptr) + s - NUM_REQ) % NUM_REQ);
            for (int i = 0; i < NUM_REQ; i++) begin
                // First pass visits only starved requesters, second only the others
                if (i == idx && bus.req_valid[i] && ((s < NUM_REQ) == starved[i])
                    && n_grant < NUM_PORTS) begin
                    conflict = 1'b0;
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        if (p < n_grant && nxt_addr[p] == addr_a[i]) begin
                            conflict = 1'b1;
                        end
                    end
                    if (!conflict) begin
                        grant[i] = 1'b1;
                        for (int p = 0; p < NUM_PORTS; p++) begin
                            if (p == n_grant) begin
                                nxt_en[p]   = 1'b1;
                                nxt_addr[p] = addr_a[i];
                                nxt_data[p] = data_a[i];
                            end
                        end
                        n_grant  = n_grant + 1;
                        last_idx = i;
                    end
                end
            end
        end
        nxt_ptr = PW'((last_idx + 1) % NUM_REQ);
    end

    // Handshake outputs are suppressed while reset is held
    assign bus.req_ready = rst ? '0 : grant;
    assign bus.wb_stall  = !rst && (|(bus.req_valid & ~grant));

    // Register the packed port writes and advance the rotation pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q <= '0;
            rr_ptr  <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                wr_addr_q[p] <= '0;
                wr_data_q[p] <= '0;
            end
        end else begin
            wr_en_q <= nxt_en;
            for (int p = 0; p < NUM_PORTS; p++) begin
                wr_addr_q[p] <= nxt_addr[p];
                wr_data_q[p] <= nxt_data[p];
            end
            if (|grant) begin
                rr_ptr <= nxt_ptr;
            end
        end
    end

    // Per-requester wait counters, saturating at the starvation threshold
    generate
        for (genvar gw = 0; gw < NUM_REQ; gw++) begin : g_wait
            always_ff @(posedge clk) begin
                if (rst || !bus.req_valid[gw] || grant[gw]) begin
                    wait_cnt[gw] <= '0;
                end else if (wait_cnt[gw] != STARVE_MAX) begin
                    wait_cnt[gw] <= wait_cnt[gw] + CW'(1);
                end
            end
        end
    endgenerate

    // Flatten the registered port state onto the write-port bus
    assign bus.wr_en = wr_en_q;
    generate
        for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_port
            assign bus.wr_addr[gp*AW +: AW] = wr_addr_q[gp];
            assign bus.wr_data[gp*DW +: DW] = wr_data_q[gp];
        end
    endgenerate

`ifdef WB_ARB_PERF_EN
    // Free-running grant and stall-cycle counters, wrapping modulo 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_grants       <= '0;
            perf_stall_cycles <= '0;
        end else begin
            perf_grants       <= perf_grants + 32'($countones(grant));
            perf_stall_cycles <= perf_stall_cycles + {31'd0, bus.wb_stall};
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_port_arbiter
//  Purpose  : Directed self-checking bench for wb_port_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_port_arbiter;

    localparam int NUM_REQ   = 6;
    localparam int NUM_PORTS = 4;
    localparam int AW        = 5;
    localparam int DW        = 32;

    logic clk;
    logic rst;
    int   tests;
    int   failed;

    wb_port_arbiter_if #(.NUM_REQ(NUM_REQ), .NUM_PORTS(NUM_PORTS), .AW(AW), .DW(DW)) bus ();

`ifdef WB_ARB_PERF_EN
    logic [31:0] perf_grants;
    logic [31:0] perf_stall_cycles;
`endif

    wb_port_arbiter #(
        .NUM_REQ(NUM_REQ), .NUM_PORTS(NUM_PORTS), .AW(AW), .DW(DW),
        .STARVE_LIMIT(3), .CW(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef WB_ARB_PERF_EN
        ,
        .perf_grants       (perf_grants),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_port(input string tag, input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        chk($sformatf("%s_en%0d", tag, p), {127'd0, bus.wr_en[p]}, 128'd1);
        chk($sformatf("%s_addr%0d", tag, p), {123'd0, bus.wr_addr[p*AW +: AW]}, {123'd0, a});
        chk($sformatf("%s_data%0d", tag, p), {96'd0, bus.wr_data[p*DW +: DW]}, {96'd0, d});
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid[i]         = 1'b1;
        bus.req_addr[i*AW +: AW] = a;
        bus.req_data[i*DW +: DW] = d;
    endtask

    task automatic clr_req(input int i);
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic clr_all();
        bus.req_valid = '0;
    endtask

    task automatic comb_pt();
        @(negedge clk);
    endtask

    task automatic reg_pt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_idx [6];
        tests  = 0;
        failed = 0;
        rst    = 1'b1;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        repeat (2) @(posedge clk);

        // Reset: handshake suppressed even with valid requests
        comb_pt();
        set_req(0, 5'd5, 32'hA);
        set_req(1, 5'd9, 32'hB);
        #1;
        chk("rst_ready", {122'd0, bus.req_ready}, 128'd0);
        chk("rst_stall", {127'd0, bus.wb_stall}, 128'd0);
        reg_pt();
        chk("rst_wr_en", {124'd0, bus.wr_en}, 128'd0);
        chk("rst_wr_addr", {108'd0, bus.wr_addr}, 128'd0);
        chk("rst_wr_data", bus.wr_data, 128'd0);
        chk("rst_rr_ptr", {125'd0, dut.rr_ptr}, 128'd0);

        // Two requesters, distinct addresses
        comb_pt();
        rst = 1'b0;
        #1;
        chk("t1_ready", {122'd0, bus.req_ready}, 128'b000011);
        chk("t1_stall", {127'd0, bus.wb_stall}, 128'd0);
        reg_pt();
        chk("t1_wr_en", {124'd0, bus.wr_en}, 128'b0011);
        chk_port("t1", 0, 5'd5, 32'hA);
        chk_port("t1", 1, 5'd9, 32'hB);
        chk("t1_rr_ptr", {125'd0, dut.rr_ptr}, 128'd2);

        // Idle cycle: no writes, pointer unchanged
        comb_pt();
        clr_all();
        #1;
        chk("idle_ready", {122'd0, bus.req_ready}, 128'd0);
        chk("idle_stall", {127'd0, bus.wb_stall}, 128'd0);
        reg_pt();
        chk("idle_wr_en", {124'd0, bus.wr_en}, 128'd0);
        chk("idle_rr_ptr", {125'd0, dut.rr_ptr}, 128'd2);

        // All six valid, distinct addresses, from rr_ptr = 0
        comb_pt();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) set_req(i, AW'(i + 1), 32'h100 + i);
        reg_pt();
        chk("t2_rst_ptr", {125'd0, dut.rr_ptr}, 128'd0);
        comb_pt();
        rst = 1'b0;
        #1;
        chk("t2_ready", {122'd0, bus.req_ready}, 128'b001111);
        chk("t2_stall", {127'd0, bus.wb_stall}, 128'd1);
        reg_pt();
        chk("t2_wr_en", {124'd0, bus.wr_en}, 128'b1111);
        for (int p = 0; p < 4; p++) chk_port("t2", p, AW'(p + 1), 32'h100 + p);
        chk("t2_rr_ptr", {125'd0, dut.rr_ptr}, 128'd4);
        comb_pt();
        for (int i = 0; i < 4; i++) clr_req(i);
        #1;
        chk("t2b_ready", {122'd0, bus.req_ready}, 128'b110000);
        chk("t2b_stall", {127'd0, bus.wb_stall}, 128'd0);
        reg_pt();
        chk("t2b_wr_en", {124'd0, bus.wr_en}, 128'b0011);
        chk_port("t2b", 0, 5'd5, 32'h104);
        chk_port("t2b", 1, 5'd6, 32'h105);
        chk("t2b_rr_ptr", {125'd0, dut.rr_ptr}, 128'd0);

        // Move rr_ptr to 2, then same-address conflict between req 0 and 3
        comb_pt();
        clr_all();
        set_req(1, 5'd20, 32'h1);
        reg_pt();
        chk("t3_pre_ptr", {125'd0, dut.rr_ptr}, 128'd2);
        comb_pt();
        clr_all();
        set_req(0, 5'd7, 32'hC0);
        set_req(3, 5'd7, 32'hC3);
        #1;
        chk("t3_ready", {122'd0, bus.req_ready}, 128'b001000);
        chk("t3_stall", {127'd0, bus.wb_stall}, 128'd1);
        reg_pt();
        chk("t3_wr_en", {124'd0, bus.wr_en}, 128'b0001);
        chk_port("t3", 0, 5'd7, 32'hC3);
        chk("t3_rr_ptr", {125'd0, dut.rr_ptr}, 128'd4);
        comb_pt();
        clr_req(3);
        #1;
        chk("t3b_ready", {122'd0, bus.req_ready}, 128'b000001);
        chk("t3b_stall", {127'd0, bus.wb_stall}, 128'd0);
        reg_pt();
        chk("t3b_wr_en", {124'd0, bus.wr_en}, 128'b0001);
        chk_port("t3b", 0, 5'd7, 32'hC0);
        chk("t3b_rr_ptr", {125'd0, dut.rr_ptr}, 128'd1);

        // Starvation: all six hit address 9, one grant per cycle. From
        // rr_ptr=1 plain rotation would grant 1,2,3,4,5...; starved set
        // {0,4,5} at the fourth cycle lets the lowest index (0) win instead.
        exp_idx = '{1, 2, 3, 0, 1, 2};
        comb_pt();
        for (int i = 0; i < 6; i++) set_req(i, 5'd9, 32'hD0 + i);
        for (int c = 0; c < 6; c++) begin
            if (c != 0) comb_pt();
            #1;
            chk($sformatf("t4_ready%0d", c), {122'd0, bus.req_ready}, 128'd1 << exp_idx[c]);
            chk($sformatf("t4_stall%0d", c), {127'd0, bus.wb_stall}, 128'd1);
            reg_pt();
            chk($sformatf("t4_wr_en%0d", c), {124'd0, bus.wr_en}, 128'b0001);
            chk_port($sformatf("t4c%0d", c), 0, 5'd9, 32'hD0 + exp_idx[c]);
        end
        chk("t4_rr_ptr", {125'd0, dut.rr_ptr}, 128'd3);

        // Distinct addresses: starved {3,4,5} first, then rotation grants 0
        comb_pt();
        for (int i = 0; i < 6; i++) set_req(i, AW'(i + 1), 32'h100 + i);
        #1;
        chk("t5_ready", {122'd0, bus.req_ready}, 128'b111001);
        chk("t5_stall", {127'd0, bus.wb_stall}, 128'd1);
        reg_pt();
        chk("t5_wr_en", {124'd0, bus.wr_en}, 128'b1111);
        chk_port("t5", 0, 5'd4, 32'h103);
        chk_port("t5", 3, 5'd1, 32'h100);

        // Mid-stream reset discards registered writes, then re-grants from 0
        comb_pt();
        rst = 1'b1;
        #1;
        chk("t6_ready", {122'd0, bus.req_ready}, 128'd0);
        chk("t6_stall", {127'd0, bus.wb_stall}, 128'd0);
        reg_pt();
        chk("t6_wr_en", {124'd0, bus.wr_en}, 128'd0);
        chk("t6_wr_addr", {108'd0, bus.wr_addr}, 128'd0);
        chk("t6_rr_ptr", {125'd0, dut.rr_ptr}, 128'd0);
        comb_pt();
        rst = 1'b0;
        #1;
        chk("t6b_ready", {122'd0, bus.req_ready}, 128'b001111);
        chk("t6b_stall", {127'd0, bus.wb_stall}, 128'd1);
        reg_pt();
        chk_port("t6b", 0, 5'd1, 32'h100);
        chk_port("t6b", 3, 5'd4, 32'h103);

`ifdef WB_ARB_PERF_EN
        // Ten saturated cycles: 4 grants and one stall per cycle
        comb_pt();
        rst = 1'b1;
        reg_pt();
        chk("perf_rst_g", {96'd0, perf_grants}, 128'd0);
        chk("perf_rst_s", {96'd0, perf_stall_cycles}, 128'd0);
        comb_pt();
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("perf_grants", {96'd0, perf_grants}, 128'd40);
        chk("perf_stalls", {96'd0, perf_stall_cycles}, 128'd10);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
